temp_fan_scheduler: RTL and testbench

TEMP_FAN_SCHEDULER -- requirements
Module: temp_fan_scheduler

---
 rtl/temp_fan_scheduler.sv | 155 +++++++++++++++
 tb/tb_temp_fan_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/temp_fan_scheduler.sv
// Temperature-driven fan scheduler.
// Periodically requests a sample from a temperature sensor, waits a bounded time
// for the acknowledge, and debounces the hot/cool decision into a fan command.
// A missed acknowledge raises a sticky error and forces the fan on as a fail-safe.
// Optional feature: define TEMP_FAN_HYST_EN to add a hysteresis band between
// TEMP_OFF and TEMP_ON; without it, anything below TEMP_ON counts as cool.
module temp_fan_scheduler #(
  parameter int unsigned SAMPLE_PERIOD = 16,
  parameter int unsigned ACK_TIMEOUT   = 8,
  parameter int unsigned DEBOUNCE_N    = 3,
  parameter logic [2:0]  TEMP_ON       = 3'b100,
  parameter logic [2:0]  TEMP_OFF      = 3'b011
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [2:0] temp,
  input  logic       temp_valid,
  output logic       sample_req,
  output logic       over_temp,
  output logic       fan_on,
  output logic       timeout_err
);

  localparam logic [15:0] PeriodLast = 16'(SAMPLE_PERIOD - 1);
  localparam logic [7:0]  AckLast    = 8'(ACK_TIMEOUT - 1);
  localparam logic [3:0]  DebMax     = 4'(DEBOUNCE_N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    EVAL = 2'd2
  } state_e;

  state_e      state_q;
  logic [15:0] periodCnt_q;
  logic [7:0]  ackCnt_q;
  logic [3:0]  hotCnt_q;
  logic [3:0]  coolCnt_q;
  logic [2:0]  tempLat_q;
  logic        sampleReq_q;
  logic        overTemp_q;
  logic        fanOn_q;
  logic        timeoutErr_q;

  logic        isHot;
  logic        isCool;
  logic [3:0]  hotCnt_d;
  logic [3:0]  coolCnt_d;
  logic        fanOn_d;
  logic        overTemp_d;

`ifdef TEMP_FAN_HYST_EN
  // Hysteresis build: only samples at or below TEMP_OFF count as cool.
  always_comb begin
    isCool = (tempLat_q <= TEMP_OFF);
  end
`else
  logic [2:0] unusedTempOff;
  assign unusedTempOff = TEMP_OFF;

  // Plain build: every sample that is not hot is cool, so there is no neutral band.
  always_comb begin
    isCool = !isHot;
  end
`endif

  // Classify the latched sample and work out the debounce result applied on the EVAL exit edge.
  always_comb begin
    isHot      = (tempLat_q >= TEMP_ON);
    overTemp_d = isHot;
    hotCnt_d   = 4'd0;
    coolCnt_d  = 4'd0;
    fanOn_d    = fanOn_q;
    if (isHot) begin
      hotCnt_d = (hotCnt_q == DebMax) ? DebMax : hotCnt_q + 4'd1;
      if (hotCnt_d == DebMax) begin
        fanOn_d = 1'b1;
      end
    end else if (isCool) begin
      coolCnt_d = (coolCnt_q == DebMax) ? DebMax : coolCnt_q + 4'd1;
      if (coolCnt_d == DebMax) begin
        fanOn_d = 1'b0;
      end
    end
  end

  // Scheduler FSM with all outputs registered; disabling parks it in IDLE but keeps the fan decision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      periodCnt_q  <= 16'd0;
      ackCnt_q     <= 8'd0;
      hotCnt_q     <= 4'd0;
      coolCnt_q    <= 4'd0;
      tempLat_q    <= 3'd0;
      sampleReq_q  <= 1'b0;
      overTemp_q   <= 1'b0;
      fanOn_q      <= 1'b0;
      timeoutErr_q <= 1'b0;
    end else if (!enable) begin
      state_q     <= IDLE;
      periodCnt_q <= 16'd0;
      ackCnt_q    <= 8'd0;
      sampleReq_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (periodCnt_q == PeriodLast) begin
            periodCnt_q <= 16'd0;
            sampleReq_q <= 1'b1;
            state_q     <= REQ;
          end else begin
            periodCnt_q <= periodCnt_q + 16'd1;
          end
        end
        REQ: begin
          if (temp_valid) begin
            tempLat_q    <= temp;
            timeoutErr_q <= 1'b0;
            sampleReq_q  <= 1'b0;
            ackCnt_q     <= 8'd0;
            state_q      <= EVAL;
          end else if (ackCnt_q == AckLast) begin
            ackCnt_q     <= 8'd0;
            sampleReq_q  <= 1'b0;
            timeoutErr_q <= 1'b1;
            hotCnt_q     <= 4'd0;
            coolCnt_q    <= 4'd0;
            fanOn_q      <= 1'b1;
            state_q      <= IDLE;
          end else begin
            ackCnt_q <= ackCnt_q + 8'd1;
          end
        end
        EVAL: begin
          overTemp_q <= overTemp_d;
          hotCnt_q   <= hotCnt_d;
          coolCnt_q  <= coolCnt_d;
          fanOn_q    <= fanOn_d;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sample_req  = sampleReq_q;
  assign over_temp   = overTemp_q;
  assign fan_on      = fanOn_q;
  assign timeout_err = timeoutErr_q;

endmodule

// File: tb/tb_temp_fan_scheduler.sv
// Self-checking bench for temp_fan_scheduler (SAMPLE_PERIOD=4, ACK_TIMEOUT=3, DEBOUNCE_N=3).
// The bench plays the sensor. Expected fan behaviour comes from a history of
// sample classes: the fan turns on after DEBOUNCE_N consecutive hot samples and
// off after DEBOUNCE_N consecutive cool ones. A timeout breaks every run.
module tb_temp_fan_scheduler;

  localparam int SP = 4;
  localparam int AT = 3;
  localparam int DN = 3;
  localparam logic [2:0] TON  = 3'b100;
  localparam logic [2:0] TOFF = 3'b011;

  localparam int HOT  = 1;
  localparam int COOL = 0;
  localparam int NEUT = 2;
  localparam int BRK  = 3;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic [2:0] temp;
  logic       temp_valid;
  logic       sample_req;
  logic       over_temp;
  logic       fan_on;
  logic       timeout_err;

  int nChecks = 0;
  int nFails  = 0;

  int   hist[$];
  logic expFan;
  logic expOver;
  logic expTimeout;
  int   nextReqIn;

  temp_fan_scheduler #(
    .SAMPLE_PERIOD(SP),
    .ACK_TIMEOUT  (AT),
    .DEBOUNCE_N   (DN),
    .TEMP_ON      (TON),
    .TEMP_OFF     (TOFF)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .temp       (temp),
    .temp_valid (temp_valid),
    .sample_req (sample_req),
    .over_temp  (over_temp),
    .fan_on     (fan_on),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int classOf(input logic [2:0] t);
    if (t >= TON) return HOT;
`ifdef TEMP_FAN_HYST_EN
    if (t <= TOFF) return COOL;
    return NEUT;
`else
    return COOL;
`endif
  endfunction

  function automatic int trailingRun(input int cls);
    int n;
    n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != cls) break;
      n++;
    end
    return n;
  endfunction

  task automatic modelSample(input logic [2:0] t);
    hist.push_back(classOf(t));
    expOver    = (t >= TON);
    expTimeout = 1'b0;
    if (trailingRun(HOT) >= DN) expFan = 1'b1;
    if (trailingRun(COOL) >= DN) expFan = 1'b0;
  endtask

  task automatic modelTimeout();
    hist.push_back(BRK);
    expFan     = 1'b1;
    expTimeout = 1'b1;
  endtask

  task automatic modelReset();
    hist.delete();
    expFan     = 1'b0;
    expOver    = 1'b0;
    expTimeout = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset_n    = 1'b0;
    enable     = 1'b0;
    temp_valid = 1'b0;
    temp       = 3'd0;
    repeat (2) step();
    reset_n = 1'b1;
    enable  = 1'b1;
    modelReset();
    nextReqIn = SP;
  endtask

  // Waits for the next request and checks how many edges it took.
  task automatic waitForReq(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (sample_req !== 1'b1 && n < 40);
    nChecks++;
    if (sample_req !== 1'b1 || n != nextReqIn) begin
      nFails++;
      $display("[TB] FAIL %s req_spacing: got %0d edges (sample_req=%b), expected %0d", tag, n, sample_req, nextReqIn);
    end
  endtask

  // One full request: acknowledged after k cycles, or timed out when k > AT.
  task automatic runSample(input int k, input logic [2:0] t, input bit stray, input string tag);
    waitForReq(tag);
    if (k <= AT) begin
      if (k > 1) begin
        repeat (k - 1) step();
        nChecks++;
        if (sample_req !== 1'b1) begin
          nFails++;
          $display("[TB] FAIL %s req_held: got %b expected 1", tag, sample_req);
        end
      end
      temp       = t;
      temp_valid = 1'b1;
      step();
      nChecks++;
      if (sample_req !== 1'b0 || fan_on !== expFan || timeout_err !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL %s latch_edge: req=%b fan=%b terr=%b, expected req=0 fan=%b terr=0", tag, sample_req, fan_on, timeout_err, expFan);
      end
      if (stray) temp = (t >= TON) ? 3'd0 : 3'd7;
      else temp_valid = 1'b0;
      step();
      temp_valid = 1'b0;
      modelSample(t);
      nChecks++;
      if (over_temp !== expOver || fan_on !== expFan || timeout_err !== expTimeout) begin
        nFails++;
        $display("[TB] FAIL %s eval(t=%0d): over=%b fan=%b terr=%b, expected over=%b fan=%b terr=%b", tag, t, over_temp, fan_on, timeout_err, expOver, expFan, expTimeout);
      end
      nextReqIn = SP;
    end else begin
      repeat (AT - 1) step();
      nChecks++;
      if (sample_req !== 1'b1) begin
        nFails++;
        $display("[TB] FAIL %s req_waiting: got %b expected 1", tag, sample_req);
      end
      step();
      modelTimeout();
      nChecks++;
      if (sample_req !== 1'b0 || timeout_err !== 1'b1 || fan_on !== 1'b1 || over_temp !== expOver) begin
        nFails++;
        $display("[TB] FAIL %s timeout: req=%b terr=%b fan=%b over=%b, expected req=0 terr=1 fan=1 over=%b", tag, sample_req, timeout_err, fan_on, over_temp, expOver);
      end
      if (stray) begin
        temp       = 3'd7;
        temp_valid = 1'b1;
        step();
        temp_valid = 1'b0;
        nChecks++;
        if (sample_req !== 1'b0 || over_temp !== expOver) begin
          nFails++;
          $display("[TB] FAIL %s idle_pulse: req=%b over=%b, expected req=0 over=%b", tag, sample_req, over_temp, expOver);
        end
        nextReqIn = SP - 1;
      end else begin
        nextReqIn = SP;
      end
    end
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    enable     = 1'b1;
    temp_valid = 1'b0;
    temp       = 3'd0;
    repeat (2) step();
    nChecks++;
    if (sample_req !== 1'b0 || over_temp !== 1'b0 || fan_on !== 1'b0 || timeout_err !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset_values: req=%b over=%b fan=%b terr=%b, expected all 0", sample_req, over_temp, fan_on, timeout_err);
    end
  endtask

  task automatic test_periodicity();
    doReset();
    runSample(1, 3'd2, 1'b0, "period_a");
    runSample(2, 3'd1, 1'b0, "period_b");
    runSample(3, 3'd0, 1'b0, "period_c");
    runSample(1, 3'd2, 1'b0, "period_d");
  endtask

  task automatic test_debounce_on();
    doReset();
    runSample(1, 3'd4, 1'b0, "deb_on_1");
    runSample(1, 3'd5, 1'b0, "deb_on_2");
    runSample(1, 3'd4, 1'b0, "deb_on_3");
  endtask

  task automatic test_debounce_break();
    logic [2:0] seq [5];
    seq = '{3'd4, 3'd4, 3'd2, 3'd4, 3'd4};
    doReset();
    foreach (seq[i]) runSample(1, seq[i], 1'b0, $sformatf("deb_break_%0d", i));
  endtask

  task automatic test_timeout();
    doReset();
    runSample(AT + 1, 3'd0, 1'b1, "to_miss");
    runSample(1, 3'd2, 1'b0, "to_clear");
    runSample(AT, 3'd6, 1'b1, "to_race");
    runSample(AT + 1, 3'd0, 1'b0, "to_miss2");
  endtask

  task automatic test_hysteresis();
    logic [2:0] seq [8];
    seq = '{3'd4, 3'd7, 3'd4, 3'd3, 3'd3, 3'd3, 3'd4, 3'd3};
    doReset();
    foreach (seq[i]) runSample(1, seq[i], 1'b0, $sformatf("hyst_%0d", i));
  endtask

  task automatic test_enable_drop();
    doReset();
    runSample(1, 3'd5, 1'b0, "en_hot1");
    runSample(1, 3'd5, 1'b0, "en_hot2");
    waitForReq("en_req");
    enable     = 1'b0;
    temp       = 3'd6;
    temp_valid = 1'b1;
    step();
    temp_valid = 1'b0;
    nChecks++;
    if (sample_req !== 1'b0 || fan_on !== expFan || over_temp !== expOver || timeout_err !== expTimeout) begin
      nFails++;
      $display("[TB] FAIL en_drop: req=%b fan=%b over=%b terr=%b, expected req=0 fan=%b over=%b terr=%b", sample_req, fan_on, over_temp, timeout_err, expFan, expOver, expTimeout);
    end
    repeat (6) step();
    nChecks++;
    if (sample_req !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL en_parked: got req=%b expected 0", sample_req);
    end
    enable = 1'b1;
    repeat (2) step();
    enable = 1'b0;
    step();
    enable    = 1'b1;
    nextReqIn = SP;
    runSample(1, 3'd4, 1'b0, "en_resume");
  endtask

  task automatic test_reset_mid_req();
    doReset();
    runSample(1, 3'd4, 1'b0, "rst_h1");
    runSample(1, 3'd4, 1'b0, "rst_h2");
    runSample(1, 3'd4, 1'b0, "rst_h3");
    runSample(AT + 1, 3'd0, 1'b0, "rst_to");
    waitForReq("rst_req");
    #2;
    reset_n = 1'b0;
    #1;
    nChecks++;
    if (sample_req !== 1'b0 || over_temp !== 1'b0 || fan_on !== 1'b0 || timeout_err !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL rst_async: req=%b over=%b fan=%b terr=%b, expected all 0", sample_req, over_temp, fan_on, timeout_err);
    end
    step();
    reset_n = 1'b1;
    modelReset();
    nextReqIn = SP;
    runSample(1, 3'd2, 1'b0, "rst_after");
  endtask

  task automatic test_random();
    int k;
    logic [2:0] t;
    bit stray;
    doReset();
    for (int i = 0; i < 60; i++) begin
      k     = $urandom_range(1, AT + 1);
      t     = 3'($urandom_range(0, 7));
      stray = 1'($urandom_range(0, 1));
      runSample(k, t, stray, $sformatf("rand_%0d", i));
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    enable     = 1'b0;
    temp       = 3'd0;
    temp_valid = 1'b0;
    nextReqIn  = SP;
    modelReset();
    test_reset();
    test_periodicity();
    test_debounce_on();
    test_debounce_break();
    test_timeout();
    test_hysteresis();
    test_enable_drop();
    test_reset_mid_req();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
